mips_fetch_unit: RTL and testbench

MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

---
 rtl/mips_fetch_pkg.sv | 7 +
 rtl/mips_fetch_unit_if.sv | 23 ++
 rtl/fetch_queue.sv | 42 ++++
 rtl/mips_fetch_unit.sv | 83 ++++++++
 tb/tb_mips_fetch_unit.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared fetch constants (reset PC default, instruction width, PC increment) and instruction type
package mips_fetch_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam int INSTR_W = 32;
  localparam int PC_INC = 4;
  typedef logic [INSTR_W-1:0] instr_t;
endpackage

// File: rtl/mips_fetch_unit_if.sv
// mips_fetch_unit_if: imem request/response, decode-side instruction and redirect signals; master = fetch unit, slave = memory/decode
interface mips_fetch_unit_if import mips_fetch_pkg::*; #(parameter int N = 32);
  logic imem_req_valid;
  logic [N-1:0] imem_req_addr;
  logic imem_req_ready;
  logic imem_rsp_valid;
  instr_t imem_rsp_data;
  logic instr_valid;
  instr_t instr_data;
  logic [N-1:0] instr_pc;
  logic [N-1:0] instr_pc_plus4;
  logic instr_ready;
  logic redirect_valid;
  logic [N-1:0] redirect_pc;
  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc, instr_pc_plus4,
    input imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc, instr_pc_plus4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: power-of-two FIFO (clk, reset, push/pushData, pop, flush in; headData, count out); flush wins, full push ignored
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic [WIDTH-1:0] pushData,
  input  logic pop,
  input  logic flush,
  output logic [WIDTH-1:0] headData,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic doPush, doPop;
  always_comb begin
    doPush = push && !flush && count != CW'(DEPTH);
    doPop = pop && !flush && count != '0;
    headData = mem[rdPtr];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + AW'(doPush);
      rdPtr <= rdPtr + AW'(doPop);
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end
  always_ff @(posedge clk)
    if (doPush) mem[wrPtr] <= pushData;
endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: credit-limited in-order prefetcher (clk, reset, bus master; perf_fetched/perf_flushed when FETCH_PERF_COUNT_EN)
module mips_fetch_unit import mips_fetch_pkg::*; #(
  parameter int N = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [N-1:0] RESET_PC = N'(RESET_PC_DEFAULT)
) (
  input logic clk,
  input logic reset,
  mips_fetch_unit_if.master bus
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  logic [N-1:0] fetchPc, rspPc, redirectAligned;
  logic [CW-1:0] outstanding, dropCnt, qCount;
  logic [N+INSTR_W-1:0] headEntry;
  logic creditFree, accept, dropping, push, pop;
  always_comb begin
    creditFree = ({1'b0, qCount} + {1'b0, outstanding}) < (CW+1)'(QUEUE_DEPTH);
    redirectAligned = bus.redirect_pc & ~N'(3);
    bus.imem_req_valid = !reset && !bus.redirect_valid && creditFree;
    bus.imem_req_addr = fetchPc;
    accept = bus.imem_req_valid && bus.imem_req_ready;
    dropping = dropCnt != '0;
    push = bus.imem_rsp_valid && !dropping && !bus.redirect_valid;
    bus.instr_valid = qCount != '0;
    pop = bus.instr_valid && bus.instr_ready && !bus.redirect_valid;
    bus.instr_data = bus.instr_valid ? headEntry[INSTR_W-1:0] : '0;
    bus.instr_pc = bus.instr_valid ? headEntry[N+INSTR_W-1:INSTR_W] : '0;
    bus.instr_pc_plus4 = bus.instr_valid ? headEntry[N+INSTR_W-1:INSTR_W] + N'(PC_INC) : '0;
  end
  // rspPc names the next response that will be kept; requests after a redirect are sequential, so it just follows fetchPc
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchPc <= RESET_PC;
      rspPc <= RESET_PC;
      outstanding <= '0;
      dropCnt <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(bus.imem_rsp_valid);
      if (bus.redirect_valid) begin
        fetchPc <= redirectAligned;
        rspPc <= redirectAligned;
        dropCnt <= outstanding - CW'(bus.imem_rsp_valid);
      end else begin
        if (accept) fetchPc <= fetchPc + N'(PC_INC);
        if (push) rspPc <= rspPc + N'(PC_INC);
        if (dropping && bus.imem_rsp_valid) dropCnt <= dropCnt - 1'b1;
      end
    end
  end
  fetch_queue #(.DEPTH(QUEUE_DEPTH), .WIDTH(N + INSTR_W)) u_queue (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pushData({rspPc, bus.imem_rsp_data}),
    .pop(pop),
    .flush(bus.redirect_valid),
    .headData(headEntry),
    .count(qCount)
  );
`ifdef FETCH_PERF_COUNT_EN
  logic [32:0] flushSum;
  always_comb
    flushSum = {1'b0, perf_flushed} + 33'(bus.redirect_valid ? qCount : '0)
             + 33'(bus.imem_rsp_valid && (bus.redirect_valid || dropping));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      perf_flushed <= flushSum[32] ? '1 : flushSum[31:0];
    end
  end
`endif
`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (reset) !(push && qCount == CW'(QUEUE_DEPTH)));
`endif
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: directed checks of sequential fetch, credit limit, redirect/drop, PC wrap and async reset
module tb_mips_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mips_fetch_unit_if #(.N(32)) bus();
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] perfFetched, perfFlushed;
`endif
  mips_fetch_unit #(.N(32), .QUEUE_DEPTH(4), .RESET_PC(32'h0040_0000)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef FETCH_PERF_COUNT_EN
    ,
    .perf_fetched(perfFetched),
    .perf_flushed(perfFlushed)
`endif
  );
  int checks = 0;
  int errors = 0;
  logic memOn;
  logic [31:0] pend[$], reqLog[$], popPc[$], popData[$], popP4[$];
  logic sReqValid, sValid;
  logic [31:0] sReqAddr, sPc, sPlus4, sData;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cycle();
    logic fire, popNow;
    if (memOn && pend.size() > 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data = ~pend.pop_front();
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data = '0;
    end
    #1;
    sReqValid = bus.imem_req_valid;
    sReqAddr = bus.imem_req_addr;
    sValid = bus.instr_valid;
    sPc = bus.instr_pc;
    sPlus4 = bus.instr_pc_plus4;
    sData = bus.instr_data;
    fire = sReqValid && bus.imem_req_ready;
    popNow = sValid && bus.instr_ready && !bus.redirect_valid;
    @(posedge clk);
    if (fire) begin
      pend.push_back(sReqAddr);
      reqLog.push_back(sReqAddr);
    end
    if (popNow) begin
      popPc.push_back(sPc);
      popData.push_back(sData);
      popP4.push_back(sPlus4);
    end
    @(negedge clk);
  endtask
  task automatic doReset();
    reset = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    memOn = 1'b1;
    pend.delete();
    reqLog.delete();
    popPc.delete();
    popData.delete();
    popP4.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int guard;
    doReset();
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("rst_req_valid", 32'(bus.imem_req_valid), 0);
    check("rst_instr_valid", 32'(bus.instr_valid), 0);
    check("rst_instr_data", bus.instr_data, 0);
    check("rst_instr_pc", bus.instr_pc, 0);
    check("rst_pc_plus4", bus.instr_pc_plus4, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.instr_ready = 1'b1;
    cycle();
    check("A_first_valid", 32'(sReqValid), 1);
    check("A_first_addr", sReqAddr, 32'h0040_0000);
    repeat (9) cycle();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("A_req%0d", i), reqLog[i], 32'h0040_0000 + 32'(4 * i));
      check($sformatf("A_pc%0d", i), popPc[i], 32'h0040_0000 + 32'(4 * i));
      check($sformatf("A_p4_%0d", i), popP4[i], 32'h0040_0004 + 32'(4 * i));
      check($sformatf("A_data%0d", i), popData[i], ~(32'h0040_0000 + 32'(4 * i)));
    end
    doReset();
    repeat (8) cycle();
    check("B_accepted", 32'(reqLog.size()), 4);
    check("B_req_low", 32'(sReqValid), 0);
    check("B_head_pc", sPc, 32'h0040_0000);
    bus.instr_ready = 1'b1;
    cycle();
    check("B_pop_cycle_req_low", 32'(sReqValid), 0);
    bus.instr_ready = 1'b0;
    cycle();
    check("B_after_pop_valid", 32'(sReqValid), 1);
    check("B_after_pop_addr", sReqAddr, 32'h0040_0010);
    doReset();
    bus.instr_ready = 1'b1;
    memOn = 1'b0;
    cycle();
    cycle();
    check("C_outstanding", 32'(reqLog.size()), 2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0040_0103;
    cycle();
    check("C_redirect_req_low", 32'(sReqValid), 0);
    bus.redirect_valid = 1'b0;
    memOn = 1'b1;
    cycle();
    check("C_new_valid", 32'(sReqValid), 1);
    check("C_new_addr", sReqAddr, 32'h0040_0100);
    repeat (8) cycle();
    check("C_first_pc", popPc[0], 32'h0040_0100);
    check("C_first_data", popData[0], ~32'h0040_0100);
    check("C_second_pc", popPc[1], 32'h0040_0104);
    doReset();
    bus.instr_ready = 1'b1;
    cycle();
    cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0040_0200;
    cycle();
    check("D_head_valid", 32'(sValid), 1);
    check("D_redirect_req_low", 32'(sReqValid), 0);
    bus.redirect_valid = 1'b0;
    cycle();
    check("D_queue_empty", 32'(sValid), 0);
    check("D_new_addr", sReqAddr, 32'h0040_0200);
    repeat (5) cycle();
    check("D_first_pc", popPc[0], 32'h0040_0200);
    doReset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    cycle();
    check("E_redirect_req_low", 32'(sReqValid), 0);
    bus.redirect_valid = 1'b0;
    cycle();
    check("E_addr_top", sReqAddr, 32'hFFFF_FFFC);
    cycle();
    check("E_addr_wrap", sReqAddr, 32'h0000_0000);
    guard = 0;
    while (!sValid && guard < 10) begin
      cycle();
      guard++;
    end
    check("E_valid", 32'(sValid), 1);
    check("E_pc_top", sPc, 32'hFFFF_FFFC);
    check("E_plus4_wrap", sPlus4, 32'h0000_0000);
    bus.instr_ready = 1'b1;
    cycle();
    bus.instr_ready = 1'b0;
    cycle();
    check("E_pc_zero", sPc, 32'h0000_0000);
    check("E_plus4_zero", sPlus4, 32'h0000_0004);
    doReset();
    repeat (4) cycle();
    #2;
    check("F_pre_valid", 32'(bus.instr_valid), 1);
    check("F_pre_pc", bus.instr_pc, 32'h0040_0000);
    reset = 1'b1;
    #1;
    check("F_async_instr_valid", 32'(bus.instr_valid), 0);
    check("F_async_req_valid", 32'(bus.imem_req_valid), 0);
    check("F_async_instr_pc", bus.instr_pc, 0);
    @(negedge clk);
    pend.delete();
    reqLog.delete();
    reset = 1'b0;
    cycle();
    check("F_release_valid", 32'(sReqValid), 1);
    check("F_release_addr", sReqAddr, 32'h0040_0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
